core_ifetch: RTL and testbench
==============================

// Module: core_ifetch
// PURPOSE
//  Instruction-fetch / PC-sequencing stage. It is the consumer of the branch/JALR
//  redirect (taken flag + target) produced by the execute-stage branch unit.
//  Holds the architectural fetch PC, issues word reads on the instruction bus
//  (at most one in flight) and presents {instr, pc} to decode with a valid/stall handshake.
//  On a redirect it discards wrong-path data and restarts fetch at the target.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
// PORTS
//  clk                   in   1   system clock; all state updates on rising edge
//  rst                   in   1   synchronous reset, active-high
//  i_branch_jalr         in   1   redirect request from branch unit (taken branch / JALR)
//  i_branch_jalr_target  in  32   redirect target; [1:0] forced to 2'b00 internally
//  i_stall               in   1   decode not ready; holds the output slot
//  o_ibus_req            out  1   read request
//  o_ibus_addr           out 32   word-aligned read address
//  i_ibus_gnt            in   1   request accepted this cycle (req&gnt = handshake)
//  i_ibus_rvalid         in   1   read data valid, >=1 cycle after accepting handshake
//  i_ibus_rdata          in  32   read data
//  o_instr_valid         out  1   output slot holds an instruction
//  o_instr               out 32   instruction word
//  o_instr_pc            out 32   address of o_instr
// BEHAVIOUR
//  Reset (highest priority, any state): pc=RESET_PC, state=S_REQ, drop=0,
//   o_instr_valid=0, o_instr=32'h0000_0013 (NOP), o_instr_pc=0; o_ibus_req=0 in the
//   reset cycle; first request at RESET_PC the cycle after rst falls.
//  slot_free = !o_instr_valid | !i_stall (slot empty or consumed this cycle).
//  Consume: o_instr_valid & !i_stall -> o_instr_valid clears next cycle unless reloaded.
//  While i_stall=1, o_instr/o_instr_pc/o_instr_valid are held stable.
//  States:
//   S_REQ : o_ibus_req = slot_free & !i_branch_jalr; o_ibus_addr = pc.
//           req&gnt -> pc<=pc+4 (mod 2^32, wraps), ipc<=pc, -> S_WAIT.
//           Before gnt the address may change (redirect); req may drop.
//   S_WAIT: o_ibus_req=0. rvalid -> o_instr<=rdata, o_instr_pc<=ipc,
//           o_instr_valid<=1, -> S_REQ (next request possible that same following cycle).
//   S_DROP: o_ibus_req=0; stale response outstanding. rvalid -> discard, -> S_REQ.
//  Redirect (i_branch_jalr=1, not reset), one-cycle pulse, any state:
//   pc<={target[31:2],2'b00}; o_instr_valid<=0 (wrong-path output flushed even if stalled).
//   S_REQ, no handshake this cycle -> stay S_REQ (req suppressed this cycle).
//   S_REQ with handshake impossible (req suppressed).
//   S_WAIT, no rvalid this cycle -> S_DROP.  S_WAIT with rvalid -> data discarded, S_REQ.
//   S_DROP, no rvalid -> stay S_DROP with new pc. S_DROP with rvalid -> S_REQ.
//  Latency: gnt at cycle N, rvalid at N+k -> o_instr_valid at N+k+1; next req at N+k+1.
//   Redirect at cycle R (no bus in flight) -> req at target in R+1.
//  Never more than one accepted-but-unanswered request. rvalid in S_REQ is a
//   bus error: ignored (assertion in bench).
//  Target bits [1:0] ignored; misaligned JALR targets are silently aligned.
// TESTING
//  1 rst 3 cycles, release; gnt=1, rvalid 1 cycle after -> req addr 0x0,0x4,0x8;
//    outputs {pc,instr} appear in order, valid on the cycle after each rvalid.
//  2 i_stall=1 for 5 cycles with valid instr @0x4 -> outputs frozen, no new req;
//    stall release -> req 0x8 same cycle.
//  3 redirect to 0x100 while in S_WAIT(addr 0x8), rvalid 2 cycles later with 0xDEAD ->
//    0xDEAD never valid; next req addr 0x100; pc 0x100 output next.
//  4 redirect to 0x203 in same cycle as rvalid -> data dropped; next req addr 0x200.
//  5 redirect while stalled with valid out -> o_instr_valid=0 next cycle, req at target.
//  6 rst asserted in S_WAIT, stale rvalid during reset -> ignored; req at RESET_PC;
//    pc 0xFFFF_FFFC fetch -> next addr 0x0000_0000 (wrap).

Source files
------------

// File: rtl/core_ifetch_if.sv
// Instruction-bus bundle between the fetch stage (master) and the memory side (slave).
// A request is accepted on any cycle where req and gnt are both high.
`timescale 1ns/1ps
interface core_ifetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/core_ifetch.sv
// Fetch/PC sequencing stage: one outstanding word read, a single output slot for
// decode, and a redirect path that flushes wrong-path data.
`timescale 1ns/1ps
module core_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_branch_jalr,
  input  logic [31:0]         i_branch_jalr_target,
  input  logic                i_stall,
  core_ifetch_if.master       ibus,
  output logic                o_instr_valid,
  output logic [31:0]         o_instr,
  output logic [31:0]         o_instr_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ipc_reg;
  logic [31:0] instr_reg;
  logic [31:0] instr_pc_reg;
  logic        instr_valid_reg;

  logic        slot_free;
  logic        req;
  logic [31:0] target_aligned;
  logic        unused_target_bits;

  assign slot_free          = !instr_valid_reg || !i_stall;
  // A redirect suppresses the request so the stale pc is never accepted.
  assign req                = !rst && (state_reg == S_REQ) && slot_free && !i_branch_jalr;
  assign target_aligned     = {i_branch_jalr_target[31:2], 2'b00};
  assign unused_target_bits = ^i_branch_jalr_target[1:0];

  assign ibus.req      = req;
  assign ibus.addr     = pc_reg;
  assign o_instr_valid = instr_valid_reg;
  assign o_instr       = instr_reg;
  assign o_instr_pc    = instr_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      ipc_reg         <= RESET_PC;
      instr_reg       <= 32'h0000_0013;
      instr_pc_reg    <= 32'h0000_0000;
      instr_valid_reg <= 1'b0;
    end else begin
      if (instr_valid_reg && !i_stall) begin
        instr_valid_reg <= 1'b0;
      end

      case (state_reg)
        S_REQ: begin
          // rvalid here would be a bus protocol error and is ignored.
          if (req && ibus.gnt) begin
            pc_reg    <= pc_reg + 32'd4;
            ipc_reg   <= pc_reg;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus.rvalid) begin
            if (!i_branch_jalr) begin
              instr_reg       <= ibus.rdata;
              instr_pc_reg    <= ipc_reg;
              instr_valid_reg <= 1'b1;
            end
            state_reg <= S_REQ;
          end else if (i_branch_jalr) begin
            state_reg <= S_DROP;
          end
        end
        S_DROP: begin
          if (ibus.rvalid) begin
            state_reg <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase

      // Redirect wins over the sequential pc and flushes the slot even when stalled.
      if (i_branch_jalr) begin
        pc_reg          <= target_aligned;
        instr_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_ifetch.sv
// Directed bench for core_ifetch: a small latency-programmable bus responder plus
// hand-stepped stimulus with hand-computed expected outputs.
`timescale 1ns/1ps
module tb_core_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  core_ifetch_if bus ();

  core_ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_branch_jalr        (branch),
    .i_branch_jalr_target (target),
    .i_stall              (stall),
    .ibus                 (bus.master),
    .o_instr_valid        (instr_valid),
    .o_instr              (instr),
    .o_instr_pc           (instr_pc)
  );

  always #5 clk = ~clk;

  // Responder: rvalid comes lat cycles after the accepting edge.
  logic        gnt_en  = 1'b1;
  int          lat     = 1;
  logic        ovr_en  = 1'b0;
  logic        pend    = 1'b0;
  int          cnt     = 0;
  logic [31:0] paddr   = 32'h0;

  assign bus.gnt    = gnt_en;
  assign bus.rvalid = pend && (cnt == 0);
  assign bus.rdata  = ovr_en ? 32'h0000_DEAD : (paddr ^ 32'h1357_0000);

  always @(posedge clk) begin
    if (bus.req && bus.gnt) begin
      pend  <= 1'b1;
      cnt   <= lat - 1;
      paddr <= bus.addr;
      $display("[%0t] ibus req addr=%h accepted", $time, bus.addr);
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end

  int dead_seen = 0;
  always @(negedge clk) begin
    if (instr_valid && instr == 32'h0000_DEAD) dead_seen <= dead_seen + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fake(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins);
    check({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, v});
    if (v) begin
      check({tag, "_pc"}, instr_pc, pc);
      check({tag, "_instr"}, instr, ins);
      $display("[%0t] decode sees pc=%h instr=%h", $time, instr_pc, instr);
    end
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
    #1;
    check({tag, "_req"}, {31'b0, bus.req}, {31'b0, r});
    if (r) check({tag, "_addr"}, bus.addr, a);
  endtask

  initial begin
    rst = 1'b1; branch = 1'b0; target = 32'h0; stall = 1'b0;

    // 1: reset then sequential fetch 0x0, 0x4
    repeat (3) step();
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", instr_pc, 32'h0);
    expect_req("rst", 1'b0, 32'h0);
    rst = 1'b0;
    expect_req("first", 1'b1, 32'h0);
    step(); expect_req("wait0", 1'b0, 32'h0);
    step(); expect_out("out0", 1'b1, 32'h0, fake(32'h0)); expect_req("req4", 1'b1, 32'h4);
    step(); expect_out("cons0", 1'b0, 32'h0, 32'h0);
    step(); expect_out("out4", 1'b1, 32'h4, fake(32'h4));

    // 2: stall holds the slot and blocks new requests
    stall = 1'b1;
    expect_req("stall", 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("hold", 1'b1, 32'h4, fake(32'h4));
      expect_req("hold", 1'b0, 32'h0);
    end
    stall = 1'b0; lat = 3; ovr_en = 1'b1;
    expect_req("unstall", 1'b1, 32'h8);

    // 3: redirect while waiting; stale 0xDEAD must be dropped
    step();
    branch = 1'b1; target = 32'h0000_0100;
    expect_req("br_wait", 1'b0, 32'h0);
    step(); branch = 1'b0; expect_req("drop1", 1'b0, 32'h0);
    step(); check("stale_rvalid", {31'b0, bus.rvalid}, 32'h1); expect_req("drop2", 1'b0, 32'h0);
    step(); ovr_en = 1'b0; lat = 1;
    expect_out("flushed", 1'b0, 32'h0, 32'h0); expect_req("req100", 1'b1, 32'h100);
    step();
    step(); expect_out("out100", 1'b1, 32'h100, fake(32'h100)); expect_req("req104", 1'b1, 32'h104);

    // 4: redirect to misaligned target coincident with rvalid
    step();
    branch = 1'b1; target = 32'h0000_0203;
    expect_req("br_rv", 1'b0, 32'h0);
    step(); branch = 1'b0;
    expect_out("drop104", 1'b0, 32'h0, 32'h0); expect_req("req200", 1'b1, 32'h200);

    // 5: redirect while stalled with a valid instruction
    step();
    step(); expect_out("out200", 1'b1, 32'h200, fake(32'h200));
    stall = 1'b1; branch = 1'b1; target = 32'h0000_0300;
    expect_req("br_stall", 1'b0, 32'h0);
    step(); branch = 1'b0;
    expect_out("flush_stall", 1'b0, 32'h0, 32'h0); expect_req("req300", 1'b1, 32'h300);
    stall = 1'b0; lat = 2;

    // 6: reset during wait with a stale response, then pc wrap
    step(); rst = 1'b1;
    step(); check("stale_in_rst", {31'b0, bus.rvalid}, 32'h1); expect_req("rst2", 1'b0, 32'h0);
    step(); rst = 1'b0; lat = 1;
    expect_out("post_rst", 1'b0, 32'h0, 32'h0); expect_req("req_rst_pc", 1'b1, 32'h0);
    branch = 1'b1; target = 32'hFFFF_FFFF;
    expect_req("br_wrap", 1'b0, 32'h0);
    step(); branch = 1'b0; expect_req("reqFFFC", 1'b1, 32'hFFFF_FFFC);
    step();
    step(); expect_out("outFFFC", 1'b1, 32'hFFFF_FFFC, fake(32'hFFFF_FFFC));
    expect_req("wrap0", 1'b1, 32'h0);

    check("dead_never_valid", dead_seen, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
